// File: rtl/mp3_pc_pkg.sv
// Shared definitions for the MP3 player button conditioning path.
// Timing defaults assume the 50 MHz system clock.
package mp3_pc_pkg;

    localparam int NUM_BUTTONS  = 4;
    localparam int DEBOUNCE_CYC = 500_000;
    localparam int HOLD_CYC     = 25_000_000;
    localparam int REPEAT_CYC   = 5_000_000;

    typedef enum logic [1:0] {
        REL = 2'd0,
        PRS = 2'd1,
        RPT = 2'd2
    } btn_state_t;

endpackage

// File: rtl/mp3_button_conditioner_if.sv
// Raw key inputs and conditioned button outputs between the board keys and the
// MP3_PC button PIO.
interface mp3_button_conditioner_if;
    import mp3_pc_pkg::*;

    logic [NUM_BUTTONS-1:0] key_n_i;
    logic [NUM_BUTTONS-1:0] btn_level_o;
    logic [NUM_BUTTONS-1:0] btn_press_o;
    logic [NUM_BUTTONS-1:0] btn_long_o;

    modport master (
        output key_n_i,
        input  btn_level_o,
        input  btn_press_o,
        input  btn_long_o
    );

    modport slave (
        input  key_n_i,
        output btn_level_o,
        output btn_press_o,
        output btn_long_o
    );

endinterface

// File: rtl/mp3_btn_channel.sv
// One button channel: 2-flop synchronizer, consecutive-sample debouncer and
// hold/auto-repeat state machine.
//
// state | meaning
// REL   | released, waiting for an accepted press
// PRS   | pressed, counting towards long-press
// RPT   | long-press reached, issuing auto-repeat ticks
module mp3_btn_channel #(
    parameter int DEBOUNCE_CYC = 500_000,
    parameter int HOLD_CYC     = 25_000_000,
    parameter int REPEAT_CYC   = 5_000_000
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic key_n,
    input  logic repeat_en,
    output logic level,
    output logic press,
    output logic held
);
    import mp3_pc_pkg::*;

    localparam int DB_W   = $clog2(DEBOUNCE_CYC);
    localparam int HOLD_W = $clog2(HOLD_CYC);
    localparam int RPT_W  = $clog2(REPEAT_CYC);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
    localparam logic [RPT_W-1:0]  RPT_LAST  = RPT_W'(REPEAT_CYC - 1);

    logic              sync_meta;
    logic              sync;
    logic [DB_W-1:0]   db_cnt;
    logic              db_level;
    logic [HOLD_W-1:0] hold_cnt;
    logic [RPT_W-1:0]  rpt_cnt;
    btn_state_t        state;
    logic              rise;
    logic              fall;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= ~key_n;
            sync      <= sync_meta;
        end
    end

    // Any sample agreeing with the accepted level restarts the count.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
        end else if (sync == db_level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_cnt   <= '0;
            db_level <= ~db_level;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // level is the registered copy of db_level, so edges are seen one cycle on.
    assign rise = db_level & ~level;
    assign fall = ~db_level & level;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state    <= REL;
            level    <= 1'b0;
            press    <= 1'b0;
            held     <= 1'b0;
            hold_cnt <= '0;
            rpt_cnt  <= '0;
        end else begin
            level <= db_level;
            press <= 1'b0;
            if (fall) begin
                state    <= REL;
                held     <= 1'b0;
                hold_cnt <= '0;
                rpt_cnt  <= '0;
            end else begin
                case (state)
                    REL: begin
                        if (rise) begin
                            press    <= 1'b1;
                            hold_cnt <= '0;
                            state    <= PRS;
                        end
                    end
                    PRS: begin
                        if (hold_cnt == HOLD_LAST) begin
                            held     <= 1'b1;
                            press    <= repeat_en;
                            hold_cnt <= '0;
                            rpt_cnt  <= '0;
                            state    <= RPT;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    RPT: begin
                        if (rpt_cnt == RPT_LAST) begin
                            rpt_cnt <= '0;
                            press   <= repeat_en;
                        end else begin
                            rpt_cnt <= rpt_cnt + 1'b1;
                        end
                    end
                    default: state <= REL;
                endcase
            end
        end
    end

endmodule

// File: rtl/mp3_button_conditioner.sv
// Conditions the four active-low board keys into clean levels, press pulses and
// long-press flags for the MP3_PC button PIO.
module mp3_button_conditioner #(
    parameter int DEBOUNCE_CYC = mp3_pc_pkg::DEBOUNCE_CYC,
    parameter int HOLD_CYC     = mp3_pc_pkg::HOLD_CYC,
    parameter int REPEAT_CYC   = mp3_pc_pkg::REPEAT_CYC,
    parameter logic [mp3_pc_pkg::NUM_BUTTONS-1:0] REPEAT_MASK = 4'b0110
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    mp3_button_conditioner_if.slave btn
);
    import mp3_pc_pkg::*;

    logic [NUM_BUTTONS-1:0] level_w;
    logic [NUM_BUTTONS-1:0] press_w;
    logic [NUM_BUTTONS-1:0] held_w;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
        mp3_btn_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .HOLD_CYC     (HOLD_CYC),
            .REPEAT_CYC   (REPEAT_CYC)
        ) u_ch (
            .clk_clk       (clk_clk),
            .reset_reset_n (reset_reset_n),
            .key_n         (btn.key_n_i[i]),
            .repeat_en     (REPEAT_MASK[i]),
            .level         (level_w[i]),
            .press         (press_w[i]),
            .held          (held_w[i])
        );
    end

    assign btn.btn_level_o = level_w;
    assign btn.btn_press_o = press_w;
    assign btn.btn_long_o  = held_w;

endmodule

// File: tb/tb_mp3_button_conditioner.sv
// Bench for mp3_button_conditioner: timing-rule reference model feeding a
// scoreboard, directed scenarios followed by randomized key activity.
module tb_mp3_button_conditioner;

    localparam int D = 4;
    localparam int H = 20;
    localparam int R = 5;
    localparam logic [3:0] MASK = 4'b0110;

    logic clk_clk = 1'b0;
    logic reset_reset_n = 1'b0;

    mp3_button_conditioner_if bus ();

    mp3_button_conditioner #(
        .DEBOUNCE_CYC (D),
        .HOLD_CYC     (H),
        .REPEAT_CYC   (R),
        .REPEAT_MASK  (MASK)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .btn           (bus)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct packed {
        logic [3:0] level;
        logic [3:0] press;
        logic [3:0] held;
    } outs_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } dir_t;

    outs_t exp_q[$];
    dir_t  dir_q[$];
    int checks = 0;
    int failures = 0;
    int press_tot[4];
    int level_tot[4];
    int held_tot[4];

    // Reference model: a change is accepted on the D-th consecutive differing
    // sample; the output level follows 3 edges later (D+2 from the first sample).
    // Press/long/repeat are then pure arithmetic on the time since the rise.
    int edge_n = 0;
    logic [3:0] acc = '0;
    logic [3:0] m_level = '0;
    int run[4];
    int chg_at[4] = '{-1, -1, -1, -1};
    int rise_at[4];

    always @(posedge clk_clk) begin
        outs_t e;
        int d;
        logic p;
        e = '0;
        edge_n++;
        if (!reset_reset_n) begin
            acc = '0;
            m_level = '0;
            for (int i = 0; i < 4; i++) begin
                run[i] = 0;
                chg_at[i] = -1;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (chg_at[i] == edge_n) begin
                    m_level[i] = ~m_level[i];
                    if (m_level[i]) rise_at[i] = edge_n;
                    chg_at[i] = -1;
                end
                p = ~bus.key_n_i[i];
                if (p == acc[i]) begin
                    run[i] = 0;
                end else begin
                    run[i]++;
                    if (run[i] == D) begin
                        acc[i] = p;
                        run[i] = 0;
                        chg_at[i] = edge_n + 3;
                    end
                end
                e.level[i] = m_level[i];
                if (m_level[i]) begin
                    d = edge_n - rise_at[i];
                    e.press[i] = (d == 0) || (d >= H && MASK[i] && ((d - H) % R) == 0);
                    e.held[i]  = (d >= H);
                end
            end
        end
        exp_q.push_back(e);
    end

    function automatic void compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk_clk) begin
        outs_t a;
        outs_t e;
        dir_t r;
        a.level = bus.btn_level_o;
        a.press = bus.btn_press_o;
        a.held  = bus.btn_long_o;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_underflow: got no expected entry, expected one per cycle (t=%0t)", $time);
        end else begin
            e = exp_q.pop_front();
            compare("btn_level_o", 32'(a.level), 32'(e.level));
            compare("btn_press_o", 32'(a.press), 32'(e.press));
            compare("btn_long_o",  32'(a.held),  32'(e.held));
        end
        while (dir_q.size() > 0) begin
            r = dir_q.pop_front();
            compare(r.name, r.act, r.exp);
        end
        for (int i = 0; i < 4; i++) begin
            press_tot[i] += int'(a.press[i]);
            level_tot[i] += int'(a.level[i]);
            held_tot[i]  += int'(a.held[i]);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    task automatic hold_key(input int ch, input logic v, input int n);
        bus.key_n_i[ch] = v;
        idle(n);
    endtask

    task automatic expect_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        dir_t r;
        r.name = name;
        r.act  = act;
        r.exp  = exp;
        dir_q.push_back(r);
    endtask

    initial begin
        int bp[4];
        int bl[4];
        int bh[4];
        int seg[4];
        logic [5:0] pat;

        bus.key_n_i = 4'hF;
        idle(3);
        #1 expect_val("reset_outputs", 32'({bus.btn_level_o, bus.btn_press_o, bus.btn_long_o}), 32'h0);
        #1 reset_reset_n = 1'b1;
        idle(10);

        // clean press/release
        bp = press_tot; bl = level_tot; bh = held_tot;
        hold_key(0, 1'b0, 10);
        hold_key(0, 1'b1, 15);
        expect_val("t1_press_count", 32'(press_tot[0] - bp[0]), 32'd1);
        expect_val("t1_level_cycles", 32'(level_tot[0] - bl[0]), 32'd10);
        expect_val("t1_long_cycles", 32'(held_tot[0] - bh[0]), 32'd0);

        // bounce then steady press
        bp = press_tot; bl = level_tot; bh = held_tot;
        pat = 6'b010010;
        for (int i = 0; i < 6; i++) hold_key(1, pat[i], 1);
        hold_key(1, 1'b0, 12);
        hold_key(1, 1'b1, 15);
        expect_val("t2_press_count", 32'(press_tot[1] - bp[1]), 32'd1);
        expect_val("t2_level_cycles", 32'(level_tot[1] - bl[1]), 32'd13);

        // long press on repeat channel: press + repeats at +20,+25,+30,+35
        bp = press_tot; bl = level_tot; bh = held_tot;
        hold_key(2, 1'b0, 40);
        hold_key(2, 1'b1, 15);
        expect_val("t3_press_count", 32'(press_tot[2] - bp[2]), 32'd5);
        expect_val("t3_level_cycles", 32'(level_tot[2] - bl[2]), 32'd40);
        expect_val("t3_long_cycles", 32'(held_tot[2] - bh[2]), 32'd20);

        // long press on non-repeat channel
        bp = press_tot; bl = level_tot; bh = held_tot;
        hold_key(3, 1'b0, 40);
        hold_key(3, 1'b1, 15);
        expect_val("t4_press_count", 32'(press_tot[3] - bp[3]), 32'd1);
        expect_val("t4_long_cycles", 32'(held_tot[3] - bh[3]), 32'd20);

        // all keys together, reset mid-hold, keys still held afterwards
        bp = press_tot;
        bus.key_n_i = 4'h0;
        idle(16);
        for (int i = 0; i < 4; i++) expect_val("t5_press_before_reset", 32'(press_tot[i] - bp[i]), 32'd1);
        #2 reset_reset_n = 1'b0;
        #1 expect_val("t5_async_clear", 32'({bus.btn_level_o, bus.btn_press_o, bus.btn_long_o}), 32'h0);
        idle(3);
        #2 reset_reset_n = 1'b1;
        idle(12);
        expect_val("t5_level_after_reset", 32'(bus.btn_level_o), 32'hF);
        bus.key_n_i = 4'hF;
        idle(15);
        for (int i = 0; i < 4; i++) expect_val("t5_press_total", 32'(press_tot[i] - bp[i]), 32'd2);

        // release accepted exactly where long-press would fire
        bp = press_tot; bl = level_tot; bh = held_tot;
        hold_key(2, 1'b0, 20);
        hold_key(2, 1'b1, 15);
        expect_val("t6_press_count", 32'(press_tot[2] - bp[2]), 32'd1);
        expect_val("t6_level_cycles", 32'(level_tot[2] - bl[2]), 32'd20);
        expect_val("t6_long_cycles", 32'(held_tot[2] - bh[2]), 32'd0);

        // randomized key activity with short bounces and one reset
        for (int i = 0; i < 4; i++) seg[i] = 0;
        for (int c = 0; c < 900; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (seg[i] == 0) begin
                    bus.key_n_i[i] = ~bus.key_n_i[i];
                    if ($urandom_range(0, 3) == 0) seg[i] = int'($urandom_range(1, 3));
                    else seg[i] = int'($urandom_range(4, 45));
                end
                seg[i]--;
            end
            if (c == 450) #2 reset_reset_n = 1'b0;
            if (c == 453) #2 reset_reset_n = 1'b1;
            idle(1);
        end
        bus.key_n_i = 4'hF;
        idle(20);
        #1 expect_val("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        idle(2);
        #1 $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
